// File: rtl/arbiter_rr_nch_pkg.sv
// Shared types for the L1-to-L2 round-robin memory arbiter.
package arbiter_rr_nch_pkg;

  localparam int unsigned LC3B_WORD_W = 16;
  localparam int unsigned LC3B_LINE_W = 128;

  typedef logic [LC3B_WORD_W-1:0] lc3b_word;
  typedef logic [LC3B_LINE_W-1:0] lc3b_mem_data;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Grant index width; a single channel still needs one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arbiter_rr_nch_rr_pick.sv
// Round-robin winner select: first requester at or after rr_ptr, wrapping.
module rr_pick
  import arbiter_rr_nch_pkg::*;
#(
  parameter  int unsigned NUM_CH = 2,
  localparam int unsigned ID_W   = id_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [ID_W-1:0]   rr_ptr,
  output logic              valid,
  output logic [ID_W-1:0]   winner
);

  localparam int unsigned DBL_W = 2 * NUM_CH;

  logic [DBL_W-1:0] dbl;
  logic [DBL_W-1:0] keep;
  logic [DBL_W-1:0] masked;

  // Doubled request vector with bits below rr_ptr masked; the upper copy supplies the wrap.
  always_comb begin
    dbl    = {req, req};
    keep   = ~((DBL_W'(1) << rr_ptr) - DBL_W'(1));
    masked = dbl & keep;
    winner = '0;
    for (int i = int'(DBL_W) - 1; i >= 0; i--) begin
      if (masked[i]) begin
        winner = (i >= int'(NUM_CH)) ? ID_W'(i - int'(NUM_CH)) : ID_W'(i);
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/arbiter_rr_nch.sv
// N-channel round-robin arbiter between the L1 pmem ports and the shared L2 port.
module arbiter_rr_nch
  import arbiter_rr_nch_pkg::*;
#(
  parameter  int unsigned NUM_CH = 2,
  parameter  int unsigned ADDR_W = LC3B_WORD_W,
  parameter  int unsigned DATA_W = LC3B_LINE_W,
  localparam int unsigned ID_W   = id_width(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_read,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*ADDR_W-1:0] ch_address,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_resp,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic                     l2_mem_read,
  output logic                     l2_mem_write,
  output logic [ADDR_W-1:0]        l2_mem_address,
  output logic [DATA_W-1:0]        l2_mem_wdata,
  input  logic                     l2_mem_resp,
  input  logic [DATA_W-1:0]        l2_mem_rdata,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy
);

  arb_state_t        state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic              op_write_q, op_write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [NUM_CH-1:0] req;
  logic              pick_valid;
  logic [ID_W-1:0]   pick_id;

  assign req = ch_read | ch_write;

  rr_pick #(
    .NUM_CH (NUM_CH)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .winner (pick_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Grant FSM: latch the winner's request in IDLE, release on L2 completion.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d = ARB_BUSY;
          grant_d = pick_id;
          for (int i = 0; i < int'(NUM_CH); i++) begin
            if (pick_id == ID_W'(i)) begin
              op_write_d = ch_write[i];
              addr_d     = ch_address[i*ADDR_W +: ADDR_W];
              wdata_d    = ch_wdata[i*DATA_W +: DATA_W];
            end
          end
        end
      end
      ARB_BUSY: begin
        if (l2_mem_resp) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = (grant_q == ID_W'(NUM_CH - 1)) ? '0 : grant_q + ID_W'(1);
        end
      end
    endcase
  end

  assign busy           = (state_q == ARB_BUSY);
  assign l2_mem_read    = busy & ~op_write_q;
  assign l2_mem_write   = busy & op_write_q;
  assign l2_mem_address = addr_q;
  assign l2_mem_wdata   = wdata_q;
  assign grant_id       = grant_q;
  assign ch_rdata       = l2_mem_rdata;

  // Completion pulse routed to the granted channel only.
  always_comb begin
    ch_resp = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      ch_resp[i] = busy & l2_mem_resp & (grant_q == ID_W'(i));
    end
  end

endmodule

// File: tb/tb_arbiter_rr_nch.sv
// Bench for arbiter_rr_nch: directed scenarios plus randomized traffic against a behavioural model.
module tb_arbiter_rr_nch;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 128;
  localparam int ID_W   = 2;

  logic                     clk;
  logic                     rst;
  logic [NUM_CH-1:0]        ch_read;
  logic [NUM_CH-1:0]        ch_write;
  logic [NUM_CH*ADDR_W-1:0] ch_address;
  logic [NUM_CH*DATA_W-1:0] ch_wdata;
  logic [NUM_CH-1:0]        ch_resp;
  logic [DATA_W-1:0]        ch_rdata;
  logic                     l2_mem_read;
  logic                     l2_mem_write;
  logic [ADDR_W-1:0]        l2_mem_address;
  logic [DATA_W-1:0]        l2_mem_wdata;
  logic                     l2_mem_resp;
  logic [DATA_W-1:0]        l2_mem_rdata;
  logic [ID_W-1:0]          grant_id;
  logic                     busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 1'b0;

  arbiter_rr_nch #(
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ch_read        (ch_read),
    .ch_write       (ch_write),
    .ch_address     (ch_address),
    .ch_wdata       (ch_wdata),
    .ch_resp        (ch_resp),
    .ch_rdata       (ch_rdata),
    .l2_mem_read    (l2_mem_read),
    .l2_mem_write   (l2_mem_write),
    .l2_mem_address (l2_mem_address),
    .l2_mem_wdata   (l2_mem_wdata),
    .l2_mem_resp    (l2_mem_resp),
    .l2_mem_rdata   (l2_mem_rdata),
    .grant_id       (grant_id),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one outstanding grant, pointer advances past the last winner.
  bit                m_busy  = 1'b0;
  int                m_rr    = 0;
  int                m_grant = 0;
  bit                m_write = 1'b0;
  logic [ADDR_W-1:0] m_addr  = '0;
  logic [DATA_W-1:0] m_wdata = '0;
  int                m_c;

  always @(posedge clk) begin
    if (rst) begin
      m_busy  = 1'b0;
      m_rr    = 0;
      m_grant = 0;
      m_write = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
    end else if (!m_busy) begin
      for (int k = 0; k < NUM_CH; k++) begin
        m_c = (m_rr + k) % NUM_CH;
        if (!m_busy && (ch_read[m_c] || ch_write[m_c])) begin
          m_busy  = 1'b1;
          m_grant = m_c;
          m_write = ch_write[m_c];
          m_addr  = ch_address[m_c*ADDR_W +: ADDR_W];
          m_wdata = ch_wdata[m_c*DATA_W +: DATA_W];
        end
      end
    end else if (l2_mem_resp) begin
      m_busy = 1'b0;
      m_rr   = (m_grant + 1) % NUM_CH;
    end
  end

  logic [NUM_CH-1:0] exp_resp;

  always @(negedge clk) begin
    if (started) begin
      exp_resp = '0;
      if (m_busy && l2_mem_resp) exp_resp[m_grant] = 1'b1;
      check("m_busy", DATA_W'(busy), DATA_W'(m_busy));
      check("m_l2_read", DATA_W'(l2_mem_read), DATA_W'(m_busy && !m_write));
      check("m_l2_write", DATA_W'(l2_mem_write), DATA_W'(m_busy && m_write));
      check("m_grant_id", DATA_W'(grant_id), DATA_W'(m_grant));
      check("m_ch_resp", DATA_W'(ch_resp), DATA_W'(exp_resp));
      if (m_busy) check("m_l2_addr", DATA_W'(l2_mem_address), DATA_W'(m_addr));
      if (m_busy && m_write) check("m_l2_wdata", l2_mem_wdata, m_wdata);
      if (exp_resp != '0) check("m_ch_rdata", ch_rdata, l2_mem_rdata);
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert ((ch_read & ch_write) == '0)
        else $error("FAIL rw_exclusive: ch_read=%b ch_write=%b", ch_read, ch_write);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int ch, input logic [ADDR_W-1:0] a);
    ch_address[ch*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic set_wdata(input int ch, input logic [DATA_W-1:0] d);
    ch_wdata[ch*DATA_W +: DATA_W] = d;
  endtask

  // Requests already set during an idle cycle; run one grant with L2 answering in cycle lat.
  task automatic txn(input int g, input bit wr, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] rd,
                     input int lat, input bit scramble, input bit drop);
    for (int c = 1; c <= lat; c++) begin
      tick();
      l2_mem_resp  = (c == lat);
      l2_mem_rdata = rd;
      if (c == 1 && scramble) begin
        ch_address = '1;
        ch_wdata   = ~ch_wdata;
      end
      if (c == 1 && drop) begin
        ch_read[g]  = 1'b0;
        ch_write[g] = 1'b0;
      end
      @(negedge clk);
      check("t_busy", DATA_W'(busy), DATA_W'(1'b1));
      check("t_grant", DATA_W'(grant_id), DATA_W'(g));
      check("t_l2_read", DATA_W'(l2_mem_read), DATA_W'(!wr));
      check("t_l2_write", DATA_W'(l2_mem_write), DATA_W'(wr));
      check("t_l2_addr", DATA_W'(l2_mem_address), DATA_W'(a));
      if (wr) check("t_l2_wdata", l2_mem_wdata, wd);
      check("t_ch_resp", DATA_W'(ch_resp), (c == lat) ? (DATA_W'(1) << g) : DATA_W'(0));
      if (c == lat && !wr) check("t_ch_rdata", ch_rdata, rd);
    end
    tick();
    l2_mem_resp = 1'b0;
    @(negedge clk);
    check("t_idle_after", DATA_W'(busy), DATA_W'(1'b0));
    check("t_strobes_drop", DATA_W'({l2_mem_read, l2_mem_write}), DATA_W'(2'b00));
  endtask

  logic [DATA_W-1:0] w_line;

  initial begin
    rst          = 1'b1;
    ch_read      = '0;
    ch_write     = '0;
    ch_address   = '0;
    ch_wdata     = '0;
    l2_mem_resp  = 1'b0;
    l2_mem_rdata = '0;
    w_line       = {32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'hCAFE_F00D};

    tick();
    tick();
    rst     = 1'b0;
    started = 1'b1;
    @(negedge clk);
    check("rst_busy", DATA_W'(busy), DATA_W'(1'b0));
    check("rst_grant", DATA_W'(grant_id), DATA_W'(0));
    check("rst_strobes", DATA_W'({l2_mem_read, l2_mem_write}), DATA_W'(2'b00));
    check("rst_ch_resp", DATA_W'(ch_resp), DATA_W'(0));

    // Single read on channel 0, L2 answers in cycle 4.
    tick();
    set_addr(0, 16'h1230);
    ch_read = 4'b0001;
    @(negedge clk);
    check("read_cycle0_idle", DATA_W'(busy), DATA_W'(1'b0));
    txn(0, 1'b0, 16'h1230, '0, {16{8'hA5}}, 4, 1'b0, 1'b0);
    ch_read = '0;

    // Contention: pointer now 1, so grants go 1,0,1,0.
    set_addr(1, 16'h2341);
    ch_read = 4'b0011;
    txn(1, 1'b0, 16'h2341, '0, 128'h11, 2, 1'b0, 1'b0);
    txn(0, 1'b0, 16'h1230, '0, 128'h22, 1, 1'b0, 1'b0);
    txn(1, 1'b0, 16'h2341, '0, 128'h33, 3, 1'b0, 1'b0);
    txn(0, 1'b0, 16'h1230, '0, 128'h44, 1, 1'b0, 1'b0);
    ch_read = '0;

    // Write on channel 1; requester rewrites its address/data after the grant.
    set_addr(1, 16'h4000);
    set_wdata(1, w_line);
    ch_write = 4'b0010;
    txn(1, 1'b1, 16'h4000, w_line, '0, 3, 1'b1, 1'b0);
    ch_write = '0;

    // Move pointer to 3, then channels 3 and 0 contend across the wrap.
    set_addr(2, 16'h3333);
    ch_read = 4'b0100;
    txn(2, 1'b0, 16'h3333, '0, 128'h55, 1, 1'b0, 1'b0);
    set_addr(3, 16'h7777);
    set_addr(0, 16'h1230);
    ch_read = 4'b1001;
    txn(3, 1'b0, 16'h7777, '0, 128'h66, 2, 1'b0, 1'b0);
    ch_read = 4'b0001;
    txn(0, 1'b0, 16'h1230, '0, 128'h77, 1, 1'b0, 1'b0);
    set_addr(1, 16'h2341);
    set_addr(2, 16'h3333);
    ch_read = 4'b0110;
    txn(1, 1'b0, 16'h2341, '0, 128'h88, 1, 1'b0, 1'b0);
    ch_read = '0;

    // Channel 0 withdraws mid-transaction; completion still reaches it.
    ch_read = 4'b0001;
    txn(0, 1'b0, 16'h1230, '0, 128'h99, 3, 1'b0, 1'b1);
    ch_read = '0;

    // Reset during a pending read, then a stale L2 response.
    set_addr(2, 16'h3333);
    ch_read = 4'b0100;
    tick();
    @(negedge clk);
    check("rstmid_busy_before", DATA_W'(busy), DATA_W'(1'b1));
    check("rstmid_grant_before", DATA_W'(grant_id), DATA_W'(2));
    tick();
    rst     = 1'b1;
    ch_read = '0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_busy", DATA_W'(busy), DATA_W'(1'b0));
    check("rstmid_strobes", DATA_W'({l2_mem_read, l2_mem_write}), DATA_W'(2'b00));
    check("rstmid_grant", DATA_W'(grant_id), DATA_W'(0));
    check("rstmid_addr", DATA_W'(l2_mem_address), DATA_W'(0));
    tick();
    l2_mem_resp = 1'b1;
    @(negedge clk);
    check("stale_resp", DATA_W'(ch_resp), DATA_W'(0));
    check("stale_busy", DATA_W'(busy), DATA_W'(1'b0));
    tick();
    l2_mem_resp = 1'b0;
    set_addr(3, 16'h7777);
    set_addr(0, 16'h1230);
    ch_read = 4'b1001;
    txn(0, 1'b0, 16'h1230, '0, 128'hAA, 1, 1'b0, 1'b0);
    ch_read = '0;

    // Randomized traffic, stale responses and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 2))
            0:       begin ch_read[c] = 1'b0; ch_write[c] = 1'b0; end
            1:       begin ch_read[c] = 1'b1; ch_write[c] = 1'b0; end
            default: begin ch_read[c] = 1'b0; ch_write[c] = 1'b1; end
          endcase
          ch_address[c*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
          ch_wdata[c*DATA_W +: DATA_W]   = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      l2_mem_resp  = ($urandom_range(0, 2) == 0);
      l2_mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    end
    tick();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arbiter_rr_nch.md
Name: arbiter_rr_nch

Overview:
- Parametrised N-channel round-robin memory arbiter between the L1 caches (I, D, later prefetcher/victim buffer) and the shared L2.
- Replaces the fixed 2:1 select with an internal grant FSM and request latching.
- Fair rotation among channels; per-channel response routing back to requesters.
- Sits between the L1 pmem ports and the L2 mem port.

Parameters:
- NUM_CH, 2, number of requesting channels (>=1); channel 0 = I-cache, 1 = D-cache by convention.
- ADDR_W, 16, address width (lc3b_word).
- DATA_W, 128, line width (lc3b_mem_data).
- ID_W, $clog2(NUM_CH) with minimum 1, grant index width (derived; not to be overridden).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous active-high reset.
- ch_read  in  NUM_CH  per-channel read request (level, held until ch_resp).
- ch_write  in  NUM_CH  per-channel write request (level, held until ch_resp).
- ch_address  in  NUM_CH*ADDR_W  packed addresses; channel i at [i*ADDR_W +: ADDR_W].
- ch_wdata  in  NUM_CH*DATA_W  packed write lines; same packing.
- ch_resp  out  NUM_CH  one-hot completion pulse to the granted channel.
- ch_rdata  out  DATA_W  read line, broadcast to all channels; valid only where ch_resp is high.
- l2_mem_read  out  1  read to L2.
- l2_mem_write  out  1  write to L2.
- l2_mem_address  out  ADDR_W  L2 address.
- l2_mem_wdata  out  DATA_W  L2 write line.
- l2_mem_resp  in  1  L2 completion.
- l2_mem_rdata  in  DATA_W  L2 read line.
- grant_id  out  ID_W  currently or last granted channel (debug/perf).
- busy  out  1  high while in BUSY.

Behaviour:
- States: IDLE, BUSY.
- Reset (rst=1 at clk edge), from any state including mid-transaction:
  - state=IDLE, rr_ptr=0, grant_id=0, latched op/address/wdata=0.
  - l2_mem_read=l2_mem_write=0, busy=0, ch_resp=0.
- Request: channel i requests when ch_read[i] | ch_write[i].
- IDLE, no requests: stay in IDLE; all L2 strobes low.
- IDLE, any requests, at the clock edge:
  - Winner = first requesting channel scanning rr_ptr, rr_ptr+1, ... mod NUM_CH.
  - Latch winner into grant_id; latch its address, wdata and op.
  - Go to BUSY.
- Op encoding: write wins if read and write are both asserted on the same channel. This is an illegal input; the bench flags it with an assertion.
- Latency: request visible in cycle 0 -> L2 strobe asserted in cycle 1. Minimum grant-to-grant spacing is 1 idle cycle.
- BUSY:
  - L2 outputs driven only from latched registers, so requester changes are ignored.
  - Exactly one of l2_mem_read/l2_mem_write is high; busy=1.
- BUSY and l2_mem_resp=1, same cycle (combinational):
  - ch_resp[grant_id]=1; all other ch_resp bits 0.
  - ch_rdata=l2_mem_rdata.
- BUSY and l2_mem_resp=1, at the clock edge:
  - State -> IDLE; rr_ptr <= (grant_id+1) mod NUM_CH.
  - L2 strobes drop in the next cycle.
- Requester drops its request mid-BUSY: the transaction still completes and ch_resp still pulses.
- l2_mem_resp in IDLE (stale, e.g. after reset): ignored; ch_resp stays 0.
- ch_rdata when no resp: drive l2_mem_rdata passthrough (don't-care to consumers).
- NUM_CH=1: ID_W=1, grant_id always 0; behaviour degenerates to a registered pass-through with one idle cycle between transactions.
- Pointer wrap: grant of channel NUM_CH-1 sets rr_ptr=0.

Decomposition:
- lc3b_types: reuse lc3b_word and lc3b_mem_data.
- Add arb_state_t enum {ARB_IDLE, ARB_BUSY} to the shared package.
- Sub-module rr_pick: combinational, parametrised on NUM_CH.
  - Inputs: req vector, rr_ptr. Outputs: valid, winner index.
  - Implemented as a double-width mask/priority-encode.
- Top module holds the FSM, latches and response demux.

Test Plan:
- Single read:
  - Stimulus: NUM_CH=2; ch_read=2'b01, address 0x1230; L2 resp after 3 cycles with rdata 0xA5..A5.
  - Required response: l2_mem_read high cycles 1-4; ch_resp=2'b01 on the resp cycle with ch_rdata=0xA5..A5; rr_ptr=1.
- Contention rotation:
  - Stimulus: both channels request continuously.
  - Required response: grants alternate 0,1,0,1; each ch_resp is one-hot; no channel is granted twice in a row.
- Write latch isolation:
  - Stimulus: ch_write[1] with address 0x4000, wdata W; the channel changes its address to 0xFFFF after the grant.
  - Required response: l2_mem_address stays 0x4000 and l2_mem_wdata stays W until resp.
- Reset mid-BUSY:
  - Stimulus: assert rst during a pending read, then pulse l2_mem_resp one cycle after rst drops.
  - Required response: outputs 0 the cycle after rst; ch_resp stays 0 on the stale resp; rr_ptr=0.
- NUM_CH=4 wrap:
  - Stimulus: requests on channels 3 and 0 with rr_ptr=3.
  - Required response: channel 3 is granted first, then channel 0; rr_ptr ends at 1.
- Request withdrawal:
  - Stimulus: channel 0 drops ch_read while BUSY.
  - Required response: the L2 read still completes; ch_resp[0] pulses; the FSM returns to IDLE.
